// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : Data-memory bus between the MEM-stage access unit (master) and
//            the data memory (slave). Also carries the opcode encodings used
//            by the access unit's decoder.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef MEM_ACCESS_OPCODES
`define MEM_ACCESS_OPCODES
`define LOAD_BYTE          6'h20
`define LOAD_HALF          6'h21
`define LOAD_WORD          6'h23
`define LOAD_BYTE_UNSIGNED 6'h24
`define LOAD_HALF_UNSIGNED 6'h25
`define STORE_BYTE         6'h28
`define STORE_HALF         6'h29
`define STORE_WORD         6'h2B
`endif

interface mem_access_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              ma_o_mem_req;
  logic              ma_o_mem_we;
  logic [AWIDTH-1:0] ma_o_mem_addr;
  logic [3:0]        ma_o_mem_be;
  logic [DWIDTH-1:0] ma_o_mem_wdata;
  logic              ma_i_mem_ack;
  logic [DWIDTH-1:0] ma_i_mem_rdata;

  modport master (
    output ma_o_mem_req, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_be, ma_o_mem_wdata,
    input  ma_i_mem_ack, ma_i_mem_rdata
  );

  modport slave (
    input  ma_o_mem_req, ma_o_mem_we, ma_o_mem_addr, ma_o_mem_be, ma_o_mem_wdata,
    output ma_i_mem_ack, ma_i_mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// Module   : mem_access
// Purpose  : MEM-stage load/store unit. Runs one req/ack transaction per
//            aligned memory op, stalls the pipeline meanwhile, right-justifies
//            load data, builds byte enables / replicated store data, and
//            reports misalignment and bus timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 32,
  parameter int TIMEOUT      = 255,
  parameter int OPCODE_WIDTH = 6
) (
  input  wire logic                    ma_i_clk,
  input  wire logic                    ma_i_rst,
  input  wire logic                    ma_i_valid,
  input  wire logic [OPCODE_WIDTH-1:0] ma_i_opcode,
  input  wire logic [AWIDTH-1:0]       ma_i_addr,
  input  wire logic [DWIDTH-1:0]       ma_i_store_data,
  output logic                         ma_o_stall,
  output logic                         ma_o_done,
  output logic [DWIDTH-1:0]            ma_o_load_data,
  output logic                         ma_o_misaligned,
  output logic                         ma_o_bus_err,
  mem_access_if.master                 bus
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [7:0] TMO     = TIMEOUT[7:0];

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [3:0]        be_q, be_d;
  logic [DWIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]        off_q, off_d;
  logic [DWIDTH-1:0] load_data_q, load_data_d;
  logic              err_q, err_d;

  logic       is_load, is_store;
  logic [1:0] size;
  logic [1:0] off;
  logic       mis;
  logic [3:0] be_new;
  logic [DWIDTH-1:0] wdata_new;

  assign off = ma_i_addr[1:0];

  // Opcode decode plus the size-dependent byte enables, lane data and alignment check
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    size      = SZ_WORD;
    case (ma_i_opcode)
      `LOAD_WORD:          begin is_load  = 1'b1; size = SZ_WORD; end
      `LOAD_HALF,
      `LOAD_HALF_UNSIGNED: begin is_load  = 1'b1; size = SZ_HALF; end
      `LOAD_BYTE,
      `LOAD_BYTE_UNSIGNED: begin is_load  = 1'b1; size = SZ_BYTE; end
      `STORE_WORD:         begin is_store = 1'b1; size = SZ_WORD; end
      `STORE_HALF:         begin is_store = 1'b1; size = SZ_HALF; end
      `STORE_BYTE:         begin is_store = 1'b1; size = SZ_BYTE; end
      default:             begin is_load  = 1'b0; is_store = 1'b0; end
    endcase
    mis       = ((size == SZ_WORD) && (off != 2'd0)) || ((size == SZ_HALF) && off[0]);
    be_new    = 4'b1111;
    wdata_new = ma_i_store_data;
    if (size == SZ_BYTE) begin
      be_new    = 4'b0001 << off;
      wdata_new = DWIDTH'({4{ma_i_store_data[7:0]}});
    end else if (size == SZ_HALF) begin
      be_new    = 4'b0011 << off;
      wdata_new = DWIDTH'({2{ma_i_store_data[15:0]}});
    end
  end

  // Next-state, latched bus fields and pipeline control
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    we_d            = we_q;
    addr_d          = addr_q;
    be_d            = be_q;
    wdata_d         = wdata_q;
    off_d           = off_q;
    load_data_d     = load_data_q;
    err_d           = err_q;
    ma_o_stall      = 1'b0;
    ma_o_misaligned = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ma_i_valid && (is_load || is_store)) begin
          if (mis) begin
            ma_o_misaligned = 1'b1;
          end else begin
            ma_o_stall = 1'b1;
            we_d       = is_store;
            addr_d     = {ma_i_addr[AWIDTH-1:2], 2'b00};
            be_d       = be_new;
            wdata_d    = wdata_new;
            off_d      = off;
            cnt_d      = 8'd0;
            err_d      = 1'b0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        ma_o_stall = 1'b1;
        if (bus.ma_i_mem_ack) begin
          load_data_d = we_q ? '0 : (bus.ma_i_mem_rdata >> {off_q, 3'b000});
          state_d     = S_RESP;
        end else if (cnt_q == TMO) begin
          load_data_d = '0;
          err_d       = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Combinational outputs read zero while reset is held
    if (ma_i_rst) begin
      ma_o_stall      = 1'b0;
      ma_o_misaligned = 1'b0;
    end
  end

  // State and latched-transaction registers
  always_ff @(posedge ma_i_clk or posedge ma_i_rst) begin
    if (ma_i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      be_q        <= 4'b0000;
      wdata_q     <= '0;
      off_q       <= 2'd0;
      load_data_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      off_q       <= off_d;
      load_data_q <= load_data_d;
      err_q       <= err_d;
    end
  end

  assign ma_o_done          = (state_q == S_RESP);
  assign ma_o_bus_err       = (state_q == S_RESP) && err_q;
  assign ma_o_load_data     = load_data_q;
  assign bus.ma_o_mem_req   = (state_q == S_WAIT);
  assign bus.ma_o_mem_we    = we_q;
  assign bus.ma_o_mem_addr  = addr_q;
  assign bus.ma_o_mem_be    = be_q;
  assign bus.ma_o_mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: doc/mem_access.md
# mem_access

Data-memory access unit for the MEM stage of the MIPS pipeline. Accepts a load/store from the EX/MEM register, runs a req/ack transaction on the data-memory bus, stalls the pipeline for the transaction's duration, and returns load data right-justified by byte offset. Downstream load sign/zero extension then needs only bits [7:0] or [15:0]. Also generates store byte enables and lane replication, flags misaligned accesses and bus timeouts.

## Interface
- `DWIDTH`, default 32: data width; byte-lane logic is fixed at 4 lanes.
- `AWIDTH`, default 32: address width.
- `TIMEOUT`, default 255: maximum WAIT cycles before bus error; counter width 8 bits.
- `ma_i_clk` in 1: the single clock; all state updates on the rising edge.
- `ma_i_rst` in 1: asynchronous, active-high reset.
- `ma_i_valid` in 1: EX/MEM holds a valid instruction.
- `ma_i_opcode` in `OPCODE_WIDTH`: opcode. Load macros: `LOAD_WORD`, `LOAD_HALF`, `LOAD_HALF_UNSIGNED`, `LOAD_BYTE`, `LOAD_BYTE_UNSIGNED`. Store macros: `STORE_WORD`, `STORE_HALF`, `STORE_BYTE`. All other opcodes are non-memory.
- `ma_i_addr` in AWIDTH: effective byte address.
- `ma_i_store_data` in DWIDTH: rt value for stores.
- `ma_o_stall` out 1: freeze IF..MEM this cycle.
- `ma_o_done` out 1: one-cycle pulse; the transaction is complete and `ma_o_load_data` is valid.
- `ma_o_load_data` out DWIDTH: right-justified load data.
- `ma_o_misaligned` out 1: address exception, combinational.
- `ma_o_bus_err` out 1: timeout, one-cycle pulse coincident with done.
- `ma_o_mem_req` out 1: bus request.
- `ma_o_mem_we` out 1: 1 = write.
- `ma_o_mem_addr` out AWIDTH: word address; bits [1:0] are always 0.
- `ma_o_mem_be` out 4: byte enables, with bit i covering data [8i+7:8i].
- `ma_o_mem_wdata` out DWIDTH: lane-replicated store data.
- `ma_i_mem_ack` in 1: transaction accepted/complete; rdata is valid in the same cycle.
- `ma_i_mem_rdata` in DWIDTH: read data.

## Operation
- The FSM has three states: IDLE, WAIT and RESP.
- Let off = `ma_i_addr[1:0]`.
- Misalignment rules:
  - word with off != 0, or half with off[0] = 1, is misaligned;
  - byte accesses are never misaligned.
- IDLE behaviour:
  - Non-memory op or `ma_i_valid` = 0: no action, stall = 0.
  - Valid memory op, misaligned: `ma_o_misaligned` = 1 the same cycle; no request, stall = 0, stay in IDLE.
  - Valid memory op, aligned: stall = 1. Latch we, word address, be, wdata and off into registers, clear the timeout counter, go to WAIT.
- WAIT behaviour:
  - req = 1 and stall = 1. Bus outputs are held stable until ack.
  - On ack: for loads, capture `ma_i_mem_rdata >> (8*off)`; for stores, capture 0. Go to RESP.
  - On counter reaching TIMEOUT without ack: drop req, load_data = 0, set bus_err, go to RESP.
  - Otherwise the counter increments.
- RESP behaviour: done = 1 for one cycle, stall = 0, req = 0, and bus_err is pulsed if the transaction timed out. The pipeline advances at the end of this cycle; inputs are ignored during RESP. Next state is IDLE.
- Byte enables (little-endian):
  - byte: 0001 << off;
  - half: 0011 << off;
  - word: 1111.
- Store write data:
  - byte: {4{data[7:0]}};
  - half: {2{data[15:0]}};
  - word: data.
- For loads, `ma_o_mem_be` reflects the access size the same way.
- `ma_o_load_data` holds its value outside RESP until the next capture.
- `ma_i_mem_ack` outside WAIT is ignored.

## Timing
- Reset (async, any state): go to IDLE. Every output resets to 0: stall, done, load_data, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata. The counter also resets to 0.
- Minimum latency: accept at T0 (stall = 1), req at T1 with ack at T1, RESP/done at T2. A memory op therefore occupies 3 cycles, with stall high for 2.
- Each extra cycle of ack delay adds one stall cycle.
- Timeout: with no ack, req stays high for TIMEOUT+1 cycles and RESP follows.
- Reset asserted during WAIT drops req asynchronously; no done is produced.
- Misaligned and non-memory ops have 0 added latency.
- Back-to-back memory ops: the second is accepted in the cycle after RESP.

## Test plan
- LOAD_BYTE from addr 0x1003 with rdata 0x80AABBCC and ack one cycle after req → be = 0001 << 3 = 1000, mem_addr = 0x1000. load_data = 0x00000080 in the done cycle; stall pattern 1,1,0.
- STORE_HALF of 0x1234ABCD to addr 0x2002 → we = 1, be = 1100, wdata = 0xABCDABCD, mem_addr = 0x2000; done 1 cycle after ack.
- LOAD_WORD to 0x3001 → misaligned = 1 the same cycle, req never asserts, stall = 0. LOAD_HALF to 0x3002 proceeds normally.
- LOAD_WORD with ack delayed 5 cycles → stall high for 6 cycles. req and mem_addr are stable throughout; done pulses once with the full rdata.
- No ack with TIMEOUT = 4 → req high for 5 cycles, then done = 1 and bus_err = 1 with load_data = 0, then return to IDLE. A spurious ack in IDLE afterwards has no effect.
- Assert `ma_i_rst` mid-WAIT → req and all outputs are 0 immediately. A following STORE_BYTE 0xEF to 0x4001 completes with be = 0010 and wdata = 0xEFEFEFEF.
